// File: rtl/rst_ce_seq.sv
// Reset-hold / clock-enable sequencer: holds downstream reset, then issues a divided ce cadence.
// Optional ce pulse counter enabled by defining RST_CE_SEQ_CE_COUNT_EN.
module rst_ce_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CE_DIV      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       pause,
    output logic       rst_out,
    output logic       ce,
    output logic       running,
    output logic [7:0] ce_count
);

    typedef enum logic {StHold, StRun} state_e;

    localparam logic [7:0] HoldMax = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] DivMax  = 8'(CE_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic       rst_out_q, rst_out_d;
    logic       ce_q, ce_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        div_cnt_d  = div_cnt_q;
        rst_out_d  = rst_out_q;
        ce_d       = 1'b0;
        if (rst) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            div_cnt_d  = '0;
            rst_out_d  = 1'b1;
        end else begin
            unique case (state_q)
                StHold: begin
                    rst_out_d = 1'b1;
                    if (hold_cnt_q == HoldMax && go) begin
                        // First ce and reset release land on the same edge.
                        state_d   = StRun;
                        rst_out_d = 1'b0;
                        ce_d      = 1'b1;
                        div_cnt_d = '0;
                    end else if (hold_cnt_q != HoldMax) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                StRun: begin
                    rst_out_d = 1'b0;
                    if (!pause) begin
                        if (div_cnt_q == DivMax) begin
                            div_cnt_d = '0;
                            ce_d      = 1'b1;
                        end else begin
                            div_cnt_d = div_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = StHold;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        div_cnt_q  <= div_cnt_d;
        rst_out_q  <= rst_out_d;
        ce_q       <= ce_d;
    end

    assign rst_out = rst_out_q;
    assign ce      = ce_q;
    assign running = (state_q == StRun);

`ifdef RST_CE_SEQ_CE_COUNT_EN
    logic [7:0] ce_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_count_q <= '0;
        end else if (ce_d) begin
            ce_count_q <= ce_count_q + 8'd1;
        end
    end

    assign ce_count = ce_count_q;
`else
    assign ce_count = '0;
`endif

endmodule
